// File: rtl/sram_like_pkg.sv
// Shared types and limits for the SRAM-like responder: size encodings,
// queue-entry layout and LATENCY bounds.
package sram_like_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_RSVD = 2'd3
   } size_e;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned STRB_W      = 4;
   localparam int unsigned IDX_W       = 30;
   localparam int unsigned AGE_W       = 4;
   localparam int unsigned LATENCY_MIN = 1;
   localparam int unsigned LATENCY_MAX = 15;

   // Full word address kept per entry; the top trims it to the store depth.
   typedef struct packed {
      logic              wr;
      size_e             size;
      logic [STRB_W-1:0] wstrb;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] wdata;
   } qentry_t;

endpackage

// File: rtl/sram_like_responder_if.sv
// Request/response bus between an initiator (master) and the responder (slave).
interface sram_like_responder_if;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/resp_queue.sv
// In-order request FIFO; each entry carries a saturating age counter so the
// head reports ready once LATENCY cycles have passed since its push edge.
module resp_queue
   import sram_like_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LATENCY = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  qentry_t push_data,
   input  logic    pop,
   output qentry_t head,
   output logic    head_ready,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   qentry_t          entries [DEPTH];
   logic [AGE_W-1:0] age     [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_data;
   end

   // Ages saturate at all-ones, which is never below any legal LATENCY.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (age[i] != '1) age[i] <= age[i] + AGE_W'(1);
      end
      if (do_push) age[wr_ptr] <= '0;
   end

   assign head       = entries[rd_ptr];
   assign head_ready = !empty && (age[rd_ptr] >= AGE_W'(LATENCY));

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like responder: fixed-latency, in-order, pipelined word store with
// byte-strobed writes committed at the response edge.
module sram_like_responder
   import sram_like_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned QDEPTH    = 4
) (
   input logic                  clk,
   input logic                  rst,
   sram_like_responder_if.slave bus
);

   localparam int unsigned WIDX = $clog2(MEM_WORDS);

   logic [DATA_W-1:0] store [MEM_WORDS];

   qentry_t         push_data;
   qentry_t         head;
   logic            head_ready;
   logic            full;
   logic            empty;
   logic            accept;
   logic            respond;
   logic [WIDX-1:0] head_idx;
   logic            unused_bits;

   assign accept  = bus.req && !full;
   assign respond = head_ready && !rst;

   assign bus.addr_ok = !full;
   assign bus.data_ok = respond;

   always_comb begin
      push_data       = '0;
      push_data.wr    = bus.wr;
      push_data.size  = size_e'(bus.size);
      push_data.wstrb = bus.wstrb;
      push_data.idx   = bus.addr[31:2];
      push_data.wdata = bus.wdata;
   end

   resp_queue #(
      .DEPTH   (QDEPTH),
      .LATENCY (LATENCY)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_data  (push_data),
      .pop        (respond),
      .head       (head),
      .head_ready (head_ready),
      .full       (full),
      .empty      (empty)
   );

   // Upper index bits are dropped here, so addresses alias modulo the store size.
   assign head_idx = head.idx[WIDX-1:0];

   always_ff @(posedge clk) begin
      if (respond && head.wr) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (head.wstrb[b]) store[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end

   assign bus.rdata = (respond && !head.wr) ? store[head_idx] : '0;

   assign unused_bits = ^{bus.addr[1:0], head.size, head.idx[IDX_W-1:WIDX], empty};

endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench: dut0 (LATENCY=2) and dut1 (LATENCY=8), both QDEPTH=4.
module tb_sram_like_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic        wr;
      logic [9:0]  idx;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          cyc;
      logic        has_want;
      logic [31:0] want;
   } exp_t;

   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [31:0] mem0 [1024];
   logic [31:0] mem1 [1024];
   int          last0 = 0;
   int          last1 = 0;

   sram_like_responder_if bus0 ();
   sram_like_responder_if bus1 ();

   sram_like_responder #(.MEM_WORDS(1024), .LATENCY(2), .QDEPTH(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   sram_like_responder #(.MEM_WORDS(1024), .LATENCY(8), .QDEPTH(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic r, input logic w, input logic [1:0] sz,
                        input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
      if (sel == 0) begin
         bus0.req = r; bus0.wr = w; bus0.size = sz; bus0.wstrb = s; bus0.addr = a; bus0.wdata = d;
      end else begin
         bus1.req = r; bus1.wr = w; bus1.size = sz; bus1.wstrb = s; bus1.addr = a; bus1.wdata = d;
      end
   endtask

   task automatic idle(input int sel);
      drive(sel, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0);
   endtask

   // Holds req until accepted; e returns the accepting edge number.
   task automatic issue(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] sz, input logic hw,
                        input logic [31:0] wv, output int e, output int stalls);
      exp_t x;
      bit   acc;
      int   lat;
      acc    = 1'b0;
      lat    = (sel == 0) ? 2 : 8;
      stalls = 0;
      e      = -1;
      drive(sel, 1'b1, w, sz, s, a, d);
      for (int k = 0; k < 64 && !acc; k++) begin
         @(negedge clk);
         if (((sel == 0) ? bus0.addr_ok : bus1.addr_ok) === 1'b1) begin
            acc        = 1'b1;
            e          = cyc + 1;
            x.wr       = w;
            x.idx      = a[11:2];
            x.wdata    = d;
            x.wstrb    = s;
            x.has_want = hw;
            x.want     = wv;
            if (sel == 0) begin
               x.cyc = (e + lat > last0 + 1) ? e + lat : last0 + 1;
               last0 = x.cyc;
               sb0.push_back(x);
            end else begin
               x.cyc = (e + lat > last1 + 1) ? e + lat : last1 + 1;
               last1 = x.cyc;
               sb1.push_back(x);
            end
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      chk($sformatf("d%0d_accept_timeout", sel), {31'b0, acc}, 32'd1);
   endtask

   task automatic drain(input int sel);
      int k;
      k = 0;
      while (((sel == 0) ? sb0.size() : sb1.size()) > 0 && k < 60) begin
         @(posedge clk);
         k++;
      end
      chk($sformatf("d%0d_drain_pending", sel), (sel == 0) ? sb0.size() : sb1.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic mon(input int sel);
      logic        dok;
      logic [31:0] rd;
      logic [31:0] want;
      exp_t        e;
      int          n;
      dok = (sel == 0) ? bus0.data_ok : bus1.data_ok;
      rd  = (sel == 0) ? bus0.rdata : bus1.rdata;
      n   = (sel == 0) ? sb0.size() : sb1.size();
      if (dok === 1'b1) begin
         chk($sformatf("d%0d_spurious_data_ok", sel), {31'b0, n > 0}, 32'd1);
         if (n > 0) begin
            e = (sel == 0) ? sb0.pop_front() : sb1.pop_front();
            if (e.wr) begin
               want = 32'h0;
               for (int b = 0; b < 4; b++) begin
                  if (e.wstrb[b]) begin
                     if (sel == 0) mem0[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
                     else          mem1[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
                  end
               end
            end else begin
               want = (sel == 0) ? mem0[e.idx] : mem1[e.idx];
            end
            chk($sformatf("d%0d_rdata", sel), rd, want);
            chk($sformatf("d%0d_resp_cycle", sel), cyc, e.cyc);
            if (e.has_want) chk($sformatf("d%0d_rdata_directed", sel), rd, e.want);
         end
      end else begin
         chk($sformatf("d%0d_rdata_idle", sel), rd, 32'h0);
         if (n > 0) begin
            e = (sel == 0) ? sb0[0] : sb1[0];
            chk($sformatf("d%0d_missing_data_ok", sel), {31'b0, cyc >= e.cyc}, 32'd0);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0);
         mon(1);
      end
   end

   initial begin
      int e;
      int st;
      int tot;
      int acc [8];
      int exp_off [8];
      int e0;

      exp_off = '{0, 1, 2, 3, 10, 11, 12, 13};

      rst = 1'b1;
      idle(0);
      idle(1);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_data_ok_d0", {31'b0, bus0.data_ok}, 32'd0);
      chk("rst_rdata_d0", bus0.rdata, 32'h0);
      chk("rst_data_ok_d1", {31'b0, bus1.data_ok}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_addr_ok_d0", {31'b0, bus0.addr_ok}, 32'd1);
      chk("post_rst_addr_ok_d1", {31'b0, bus1.addr_ok}, 32'd1);
      chk("post_rst_rdata_d0", bus0.rdata, 32'h0);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Write then read back; write response carries zero data.
      issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'd2, 1'b1, 32'h0, e, st);
      issue(0, 1'b0, 32'h100, 32'h0, 4'hF, 2'd2, 1'b1, 32'hDEADBEEF, e, st);
      idle(0);
      drain(0);

      // Partial strobe merges into the existing word.
      issue(0, 1'b1, 32'h0, 32'h11223344, 4'hF, 2'd2, 1'b1, 32'h0, e, st);
      issue(0, 1'b1, 32'h0, 32'h0000AA00, 4'b0010, 2'd1, 1'b1, 32'h0, e, st);
      issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd2, 1'b1, 32'h1122AA44, e, st);
      idle(0);
      drain(0);

      // Address 0x1000 aliases word 0 in a 1024-word store.
      issue(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 2'd2, 1'b1, 32'h0, e, st);
      issue(0, 1'b0, 32'h1000, 32'h0, 4'h0, 2'd2, 1'b1, 32'hCAFEF00D, e, st);
      idle(0);
      drain(0);

      // wstrb=0 is a no-op write; misaligned byte write only touches strobed lane.
      issue(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 2'd2, 1'b1, 32'h0, e, st);
      issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd2, 1'b1, 32'hCAFEF00D, e, st);
      issue(0, 1'b1, 32'h3, 32'h77000000, 4'b1000, 2'd0, 1'b1, 32'h0, e, st);
      issue(0, 1'b0, 32'h2, 32'h0, 4'h0, 2'd3, 1'b1, 32'h77FEF00D, e, st);
      idle(0);
      drain(0);

      // Streaming: 8 writes then 8 reads with req held high.
      for (int i = 0; i < 8; i++)
         issue(0, 1'b1, 32'h200 + 32'(4 * i), 32'hA5000000 + 32'(i), 4'hF, 2'd2, 1'b0, 32'h0, e, st);
      idle(0);
      drain(0);
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0, 2'd2, 1'b1, 32'hA5000000 + 32'(i), acc[i], st);
         tot += st;
      end
      idle(0);
      chk("stream_stalls", tot, 32'd0);
      for (int i = 1; i < 8; i++)
         chk($sformatf("stream_accept_%0d", i), acc[i] - acc[0], i);
      drain(0);

      // LATENCY=8: reset one cycle before the first response discards pending writes.
      issue(1, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, 2'd2, 1'b1, 32'h0, e, st);
      idle(1);
      drain(1);
      issue(1, 1'b1, 32'h40, 32'h01010101, 4'hF, 2'd2, 1'b0, 32'h0, e0, st);
      issue(1, 1'b1, 32'h40, 32'h02020202, 4'hF, 2'd2, 1'b0, 32'h0, e, st);
      issue(1, 1'b1, 32'h40, 32'h03030303, 4'hF, 2'd2, 1'b0, 32'h0, e, st);
      idle(1);
      while (cyc < e0 + 7) @(posedge clk);
      #1;
      rst = 1'b1;
      sb1.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_addr_ok_d1", {31'b0, bus1.addr_ok}, 32'd1);
      chk("mid_rst_data_ok_d1", {31'b0, bus1.data_ok}, 32'd0);
      @(posedge clk);
      #1;
      issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 2'd2, 1'b1, 32'h55AA55AA, e, st);
      idle(1);
      drain(1);

      // LATENCY=8, QDEPTH=4 with req held: 4 accepts, stall, then one per response.
      for (int i = 0; i < 8; i++)
         issue(1, 1'b1, 32'h80, 32'h0, 4'h0, 2'd2, 1'b1, 32'h0, acc[i], st);
      idle(1);
      for (int i = 1; i < 8; i++)
         chk($sformatf("backpressure_accept_%0d", i), acc[i] - acc[0], exp_off[i]);
      drain(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
